cprv_mem_stage: RTL and testbench

//   MEM pipeline stage of the cprv64g core. Accepts one instruction per handshake from EX and

---
 rtl/cprv_mem_stage_if.sv | 48 ++++
 rtl/cprv_mem_stage.sv | 150 +++++++++++++++
 tb/tb_cprv_mem_stage.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cprv_mem_stage_if.sv
// EX -> MEM -> WB handshakes plus the data-memory req/ack port of the cprv64g MEM stage.
// Latency: none (wires only).
// Backpressure: ready_ex_o toward EX, ready_wb_i from WB, dmem_ack_i from memory.
// Ports:
//   EX side  : valid_ex_i, ready_ex_o, opcode_ex_i, funct3_ex_i, rd_addr_ex_i, alu_result_ex_i, rs2_data_ex_i
//   Hazard   : opcode_mem_o, rd_addr_mem_o
//   Memory   : dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o, dmem_ack_i, dmem_rdata_i
//   WB side  : valid_wb_o, ready_wb_i, rd_we_wb_o, rd_addr_wb_o, rd_data_wb_o
//   master = the MEM stage itself, slave = its environment (EX, memory, WB).
interface cprv_mem_stage_if #(parameter int XLEN = 64);
  logic            valid_ex_i;
  logic            ready_ex_o;
  logic [6:0]      opcode_ex_i;
  logic [2:0]      funct3_ex_i;
  logic [4:0]      rd_addr_ex_i;
  logic [XLEN-1:0] alu_result_ex_i;
  logic [XLEN-1:0] rs2_data_ex_i;
  logic [6:0]      opcode_mem_o;
  logic [4:0]      rd_addr_mem_o;
  logic            dmem_req_o;
  logic            dmem_we_o;
  logic [XLEN-1:0] dmem_addr_o;
  logic [XLEN-1:0] dmem_wdata_o;
  logic [7:0]      dmem_wstrb_o;
  logic            dmem_ack_i;
  logic [XLEN-1:0] dmem_rdata_i;
  logic            valid_wb_o;
  logic            ready_wb_i;
  logic            rd_we_wb_o;
  logic [4:0]      rd_addr_wb_o;
  logic [XLEN-1:0] rd_data_wb_o;

  modport master (
    input  valid_ex_i, opcode_ex_i, funct3_ex_i, rd_addr_ex_i, alu_result_ex_i, rs2_data_ex_i,
    input  dmem_ack_i, dmem_rdata_i, ready_wb_i,
    output ready_ex_o, opcode_mem_o, rd_addr_mem_o,
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o,
    output valid_wb_o, rd_we_wb_o, rd_addr_wb_o, rd_data_wb_o
  );

  modport slave (
    output valid_ex_i, opcode_ex_i, funct3_ex_i, rd_addr_ex_i, alu_result_ex_i, rs2_data_ex_i,
    output dmem_ack_i, dmem_rdata_i, ready_wb_i,
    input  ready_ex_o, opcode_mem_o, rd_addr_mem_o,
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o,
    input  valid_wb_o, rd_we_wb_o, rd_addr_wb_o, rd_data_wb_o
  );
endinterface

// File: rtl/cprv_mem_stage.sv
// MEM stage of cprv64g: LOAD/STORE over a req/ack data port, other results pass straight to WB.
// Latency: non-mem 1 cycle to valid_wb_o; mem ops 1 cycle after the ack edge (minimum 2).
// Backpressure: single-entry; accepts from EX when empty, or when WB takes the held result the same edge.
// Ports: clk, rst_n (synchronous, active low) plus the bus interface (master view), see cprv_mem_stage_if.
module cprv_mem_stage #(
  parameter int XLEN = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cprv_mem_stage_if.master      bus
);

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [6:0]      opcode_q, opcode_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] addr_q, addr_d;
  // Holds store data while in ACCESS, then the writeback value in DONE.
  logic [XLEN-1:0] rd_data_q, rd_data_d;

  logic            is_access, is_done, is_store, ready_ex, capture, ex_is_mem, writes_rd;
  logic [2:0]      lane;
  logic [7:0]      size_mask;
  logic [XLEN-1:0] ld_raw, load_data;

  assign is_access = (state_q == ST_ACCESS);
  assign is_done   = (state_q == ST_DONE);
  assign is_store  = (opcode_q == OPC_STORE);
  assign ready_ex  = (state_q == ST_IDLE) | (is_done & bus.ready_wb_i);
  assign capture   = bus.valid_ex_i & ready_ex;
  assign ex_is_mem = (bus.opcode_ex_i == OPC_LOAD) | (bus.opcode_ex_i == OPC_STORE);

  always_comb begin
    writes_rd = 1'b0;
    case (opcode_q)
      OPC_LOAD, OPC_OP, OPC_OP_IMM, OPC_OP_32, OPC_OP_IMM_32,
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: writes_rd = 1'b1;
      default:                               writes_rd = 1'b0;
    endcase
  end

  // Byte lane of the access after aligning the address down to the access size.
  always_comb begin
    lane      = 3'd0;
    size_mask = 8'h00;
    case (funct3_q[1:0])
      2'd0:    begin lane = addr_q[2:0];          size_mask = 8'h01; end
      2'd1:    begin lane = {addr_q[2:1], 1'b0};  size_mask = 8'h03; end
      2'd2:    begin lane = {addr_q[2], 2'b00};   size_mask = 8'h0F; end
      default: begin lane = 3'd0;                 size_mask = 8'hFF; end
    endcase
  end

  assign ld_raw = bus.dmem_rdata_i >> {lane, 3'b000};

  always_comb begin
    load_data = ld_raw;
    case (funct3_q)
      3'b000:  load_data = {{(XLEN-8){ld_raw[7]}},   ld_raw[7:0]};
      3'b001:  load_data = {{(XLEN-16){ld_raw[15]}}, ld_raw[15:0]};
      3'b010:  load_data = {{(XLEN-32){ld_raw[31]}}, ld_raw[31:0]};
      3'b100:  load_data = {{(XLEN-8){1'b0}},        ld_raw[7:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}},       ld_raw[15:0]};
      3'b110:  load_data = {{(XLEN-32){1'b0}},       ld_raw[31:0]};
      default: load_data = ld_raw;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    funct3_d  = funct3_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    rd_data_d = rd_data_q;
    case (state_q)
      ST_ACCESS: begin
        if (bus.dmem_ack_i) begin
          state_d   = ST_DONE;
          rd_data_d = is_store ? '0 : load_data;
        end
      end
      ST_DONE: begin
        if (bus.ready_wb_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A capture out of DONE overrides the return to IDLE, so results stream without a bubble.
    if (capture) begin
      opcode_d  = bus.opcode_ex_i;
      funct3_d  = bus.funct3_ex_i;
      rd_d      = bus.rd_addr_ex_i;
      addr_d    = bus.alu_result_ex_i;
      rd_data_d = ex_is_mem ? bus.rs2_data_ex_i : bus.alu_result_ex_i;
      state_d   = ex_is_mem ? ST_ACCESS : ST_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      opcode_q  <= '0;
      funct3_q  <= '0;
      rd_q      <= '0;
      addr_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      funct3_q  <= funct3_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.ready_ex_o    = ready_ex;
  // Zero when empty so the EX hazard staller never matches on a stale instruction.
  assign bus.opcode_mem_o  = (is_access | is_done) ? opcode_q : '0;
  assign bus.rd_addr_mem_o = (is_access | is_done) ? rd_q : '0;

  assign bus.dmem_req_o    = is_access;
  assign bus.dmem_we_o     = is_access & is_store;
  assign bus.dmem_addr_o   = is_access ? {addr_q[XLEN-1:3], lane} : '0;
  assign bus.dmem_wstrb_o  = (is_access & is_store) ? (size_mask << lane) : 8'h00;
  assign bus.dmem_wdata_o  = (is_access & is_store) ? (rd_data_q << {lane, 3'b000}) : '0;

  assign bus.valid_wb_o    = is_done;
  assign bus.rd_we_wb_o    = is_done & writes_rd & (rd_q != 5'd0);
  assign bus.rd_addr_wb_o  = is_done ? rd_q : '0;
  assign bus.rd_data_wb_o  = is_done ? rd_data_q : '0;

endmodule

// File: tb/tb_cprv_mem_stage.sv
module tb_cprv_mem_stage;
  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, OP = 7'b0110011, OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_32 = 7'b0111011, LUI = 7'b0110111, JALR = 7'b1100111, BRANCH = 7'b1100011;

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic [4:0] rd;
    logic [63:0] alu; logic [63:0] rs2; logic [63:0] rdata; int delay;
  } instr_t;
  typedef struct { logic [6:0] op; logic [4:0] rd; logic we; logic [63:0] data; } wb_t;
  typedef struct {
    logic [63:0] addr; logic we; logic [7:0] strb; logic [63:0] wdata; logic [63:0] rdata; int delay;
  } mem_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cprv_mem_stage_if #(.XLEN(64)) bus ();
  cprv_mem_stage #(.XLEN(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit writes_rd(logic [6:0] op);
    return op inside {7'b0000011, 7'b0110011, 7'b0010011, 7'b0111011, 7'b0011011,
                      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
  endfunction

  function automatic int nbytes(logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic int lane_of(instr_t t);
    int nb;
    nb = nbytes(t.f3);
    return (int'(t.alu[2:0]) / nb) * nb;
  endfunction

  function automatic logic [63:0] exp_load(instr_t t);
    int nb, ln;
    logic [63:0] v, m;
    nb = nbytes(t.f3);
    ln = lane_of(t);
    v = t.rdata >> (8 * ln);
    if (nb < 8) begin
      m = (64'd1 << (8 * nb)) - 64'd1;
      v = v & m;
      if (!t.f3[2] && v[8*nb-1]) v = v | ~m;
    end
    return v;
  endfunction

  function automatic wb_t exp_wb(instr_t t);
    wb_t w;
    w.op = t.op;
    w.rd = t.rd;
    w.we = (t.rd != 0) && writes_rd(t.op);
    if (t.op == STORE) w.data = 64'd0;
    else if (t.op == LOAD) w.data = exp_load(t);
    else w.data = t.alu;
    return w;
  endfunction

  function automatic mem_t exp_mem(instr_t t);
    mem_t m;
    int nb, ln;
    nb = nbytes(t.f3);
    ln = lane_of(t);
    m.addr  = t.alu - 64'(int'(t.alu[2:0]) % nb);
    m.we    = (t.op == STORE);
    m.strb  = m.we ? 8'(((1 << nb) - 1) << ln) : 8'h00;
    m.wdata = t.rs2 << (8 * ln);
    m.rdata = t.rdata;
    m.delay = t.delay;
    return m;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    case ($urandom_range(0, 11))
      0, 1, 2: t.op = LOAD;
      3, 4:    t.op = STORE;
      5:       t.op = OP;
      6:       t.op = OP_IMM;
      7:       t.op = OP_32;
      8:       t.op = LUI;
      9:       t.op = JALR;
      10:      t.op = BRANCH;
      default: t.op = 7'($urandom);
    endcase
    t.f3    = 3'($urandom);
    t.rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    t.alu   = {$urandom, $urandom};
    t.rs2   = {$urandom, $urandom};
    t.rdata = {$urandom, $urandom};
    t.delay = $urandom_range(0, 4);
    return t;
  endfunction

  // ---------------- random-phase bookkeeping ----------------
  wb_t    wq[$];
  mem_t   mq[$];
  instr_t cur;
  bit     cur_vld = 0;
  bit     serving = 0;
  int     cnt = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [63:0] alu, input logic [63:0] rs2);
    bus.valid_ex_i = 1'b1;
    bus.opcode_ex_i = op; bus.funct3_ex_i = f3; bus.rd_addr_ex_i = rd;
    bus.alu_result_ex_i = alu; bus.rs2_data_ex_i = rs2;
  endtask

  task automatic drive_inputs(input bit allow_new);
    if (!cur_vld && allow_new && $urandom_range(0, 3) != 0) begin
      cur = rand_instr();
      cur_vld = 1;
    end
    if (cur_vld) set_ex(cur.op, cur.f3, cur.rd, cur.alu, cur.rs2);
    else begin
      set_ex(7'($urandom), 3'($urandom), 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      bus.valid_ex_i = 1'b0;
    end
    bus.ready_wb_i = ($urandom_range(0, 3) != 0);
    if (bus.dmem_req_o && !serving && mq.size() != 0) begin
      serving = 1;
      cnt = mq[0].delay;
    end
    if (serving) begin
      bus.dmem_rdata_i = mq[0].rdata;
      bus.dmem_ack_i = (cnt == 0);
      if (cnt > 0) cnt--;
    end else begin
      bus.dmem_rdata_i = {$urandom, $urandom};
      // Stray acks while no request is up must be ignored by the stage.
      bus.dmem_ack_i = !bus.dmem_req_o && ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic check_update();
    bit exp_valid, exp_ready;
    exp_valid = (wq.size() != 0) && (mq.size() == 0);
    exp_ready = (wq.size() == 0) || ((mq.size() == 0) && bus.ready_wb_i);
    chk_eq("valid_wb", 64'(bus.valid_wb_o), 64'(exp_valid));
    chk_eq("ready_ex", 64'(bus.ready_ex_o), 64'(exp_ready));
    chk_eq("dmem_req", 64'(bus.dmem_req_o), 64'(mq.size() != 0));
    chk_eq("opcode_mem", 64'(bus.opcode_mem_o), (wq.size() != 0) ? 64'(wq[0].op) : 64'd0);
    chk_eq("rd_addr_mem", 64'(bus.rd_addr_mem_o), (wq.size() != 0) ? 64'(wq[0].rd) : 64'd0);
    if (exp_valid) begin
      chk_eq("rd_we_wb", 64'(bus.rd_we_wb_o), 64'(wq[0].we));
      chk_eq("rd_addr_wb", 64'(bus.rd_addr_wb_o), 64'(wq[0].rd));
      chk_eq("rd_data_wb", bus.rd_data_wb_o, wq[0].data);
    end
    if (serving) begin
      chk_eq("dmem_addr", bus.dmem_addr_o, mq[0].addr);
      chk_eq("dmem_we", 64'(bus.dmem_we_o), 64'(mq[0].we));
      chk_eq("dmem_wstrb", 64'(bus.dmem_wstrb_o), 64'(mq[0].strb));
      if (mq[0].we) chk_eq("dmem_wdata", bus.dmem_wdata_o, mq[0].wdata);
      if (bus.dmem_ack_i) begin
        void'(mq.pop_front());
        serving = 0;
      end
    end
    if (exp_valid && bus.ready_wb_i) void'(wq.pop_front());
    if (bus.valid_ex_i && exp_ready) begin
      wq.push_back(exp_wb(cur));
      if (cur.op == LOAD || cur.op == STORE) mq.push_back(exp_mem(cur));
      cur_vld = 0;
    end
  endtask

  task automatic rand_cycle(input bit allow_new);
    step();
    drive_inputs(allow_new);
    @(negedge clk);
    check_update();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    bus.valid_ex_i = 0; bus.opcode_ex_i = 0; bus.funct3_ex_i = 0; bus.rd_addr_ex_i = 0;
    bus.alu_result_ex_i = 0; bus.rs2_data_ex_i = 0;
    bus.dmem_ack_i = 0; bus.dmem_rdata_i = 0; bus.ready_wb_i = 0;

    // Reset
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_ready_ex", 64'(bus.ready_ex_o), 64'd1);
    chk_eq("rst_valid_wb", 64'(bus.valid_wb_o), 64'd0);
    chk_eq("rst_dmem_req", 64'(bus.dmem_req_o), 64'd0);
    chk_eq("rst_opcode_mem", 64'(bus.opcode_mem_o), 64'd0);
    chk_eq("rst_rd_data_wb", bus.rd_data_wb_o, 64'd0);
    rst_n = 1;

    // Non-memory pass-through, streaming one per cycle
    bus.ready_wb_i = 1;
    set_ex(OP, 3'd0, 5'd5, 64'h1234, 64'd0);
    step();
    chk_eq("op_valid_wb", 64'(bus.valid_wb_o), 64'd1);
    chk_eq("op_rd_we", 64'(bus.rd_we_wb_o), 64'd1);
    chk_eq("op_rd_data", bus.rd_data_wb_o, 64'h1234);
    chk_eq("op_rd_addr", 64'(bus.rd_addr_wb_o), 64'd5);
    chk_eq("op_no_req", 64'(bus.dmem_req_o), 64'd0);
    set_ex(OP, 3'd0, 5'd6, 64'h5678, 64'd0);
    step();
    chk_eq("stream_valid_wb", 64'(bus.valid_wb_o), 64'd1);
    chk_eq("stream_rd_data", bus.rd_data_wb_o, 64'h5678);
    set_ex(OP_IMM, 3'd0, 5'd0, 64'h9, 64'd0);
    step();
    chk_eq("rd0_rd_data", bus.rd_data_wb_o, 64'h9);
    chk_eq("rd0_rd_we", 64'(bus.rd_we_wb_o), 64'd0);
    bus.valid_ex_i = 0;
    step();
    chk_eq("drain_valid_wb", 64'(bus.valid_wb_o), 64'd0);

    // LB at an odd address, ack in the third request cycle
    set_ex(LOAD, 3'b000, 5'd7, 64'h1003, 64'd0);
    step();
    bus.valid_ex_i = 0;
    for (int i = 0; i < 3; i++) begin
      chk_eq("lb_req", 64'(bus.dmem_req_o), 64'd1);
      chk_eq("lb_addr", bus.dmem_addr_o, 64'h1003);
      chk_eq("lb_wstrb", 64'(bus.dmem_wstrb_o), 64'd0);
      chk_eq("lb_opcode_mem", 64'(bus.opcode_mem_o), 64'(LOAD));
      chk_eq("lb_valid_wb", 64'(bus.valid_wb_o), 64'd0);
      if (i == 2) begin
        bus.dmem_ack_i = 1;
        bus.dmem_rdata_i = 64'h0000_0000_8000_0000;
      end
      step();
    end
    bus.dmem_ack_i = 0;
    chk_eq("lb_valid_wb_done", 64'(bus.valid_wb_o), 64'd1);
    chk_eq("lb_rd_data", bus.rd_data_wb_o, 64'hFFFF_FFFF_FFFF_FF80);
    chk_eq("lb_req_drop", 64'(bus.dmem_req_o), 64'd0);

    // SH into the top lane, captured straight out of DONE, ack in the first request cycle
    set_ex(STORE, 3'b001, 5'd9, 64'h2006, 64'hABCD);
    step();
    bus.valid_ex_i = 0;
    chk_eq("sh_req", 64'(bus.dmem_req_o), 64'd1);
    chk_eq("sh_we", 64'(bus.dmem_we_o), 64'd1);
    chk_eq("sh_addr", bus.dmem_addr_o, 64'h2006);
    chk_eq("sh_wstrb", 64'(bus.dmem_wstrb_o), 64'hC0);
    chk_eq("sh_wdata", bus.dmem_wdata_o, 64'hABCD_0000_0000_0000);
    bus.dmem_ack_i = 1;
    step();
    bus.dmem_ack_i = 0;
    chk_eq("sh_valid_wb", 64'(bus.valid_wb_o), 64'd1);
    chk_eq("sh_rd_we", 64'(bus.rd_we_wb_o), 64'd0);
    chk_eq("sh_rd_data", bus.rd_data_wb_o, 64'd0);

    // WB stall for 4 cycles, then release with the next instruction waiting
    bus.ready_wb_i = 0;
    set_ex(OP, 3'd0, 5'd3, 64'h77, 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_eq("stall_valid_wb", 64'(bus.valid_wb_o), 64'd1);
      chk_eq("stall_rd_addr", 64'(bus.rd_addr_wb_o), 64'd9);
      chk_eq("stall_rd_data", bus.rd_data_wb_o, 64'd0);
      chk_eq("stall_ready_ex", 64'(bus.ready_ex_o), 64'd0);
    end
    bus.ready_wb_i = 1;
    step();
    bus.valid_ex_i = 0;
    chk_eq("release_rd_addr", 64'(bus.rd_addr_wb_o), 64'd3);
    chk_eq("release_rd_data", bus.rd_data_wb_o, 64'h77);
    step();
    chk_eq("release_idle", 64'(bus.valid_wb_o), 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) rand_cycle(1'b1);
    guard = 0;
    while ((wq.size() != 0 || cur_vld) && guard < 200) begin
      rand_cycle(1'b0);
      guard++;
    end
    chk_eq("random_drain", 64'(wq.size()), 64'd0);

    // Reset in the middle of an ACCESS, followed by a late ack
    step();
    bus.dmem_ack_i = 0;
    bus.ready_wb_i = 1;
    set_ex(LOAD, 3'b011, 5'd4, 64'h3000, 64'd0);
    step();
    bus.valid_ex_i = 0;
    step();
    chk_eq("rma_req", 64'(bus.dmem_req_o), 64'd1);
    rst_n = 0;
    step();
    chk_eq("rma_req_drop", 64'(bus.dmem_req_o), 64'd0);
    chk_eq("rma_ready_ex", 64'(bus.ready_ex_o), 64'd1);
    chk_eq("rma_opcode_mem", 64'(bus.opcode_mem_o), 64'd0);
    rst_n = 1;
    bus.dmem_ack_i = 1;
    bus.dmem_rdata_i = 64'hDEAD_BEEF_0123_4567;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_eq("late_ack_valid_wb", 64'(bus.valid_wb_o), 64'd0);
      chk_eq("late_ack_req", 64'(bus.dmem_req_o), 64'd0);
    end
    bus.dmem_ack_i = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
